// File: rtl/lfsr_keystream_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module : lfsr_keystream_arb_pkg
// Brief  : Shared types and constants for the LFSR keystream arbiter:
//          FSM state encoding, LFSR width, tap mask and default seed.
// Rev    : 1.0  initial release
// ============================================================================
package lfsr_keystream_arb_pkg;

   // Width of the keystream LFSR.
   localparam int c_lfsr_w = 8;

   // Feedback taps at bit positions 7, 6, 5 and 0.
   localparam logic [c_lfsr_w-1:0] c_lfsr_taps = 8'b1110_0001;

   // Seed substituted whenever a zero seed is loaded (zero would lock up).
   localparam logic [c_lfsr_w-1:0] c_default_seed = 8'h41;

   // Session state: no seed yet, streaming, or byte budget used up.
   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_RUN       = 2'd1,
      ST_EXHAUSTED = 2'd2
   } state_t;

endpackage
`default_nettype wire

// File: rtl/lfsr8_step.sv
`default_nettype none
// ============================================================================
// Module : lfsr8_step
// Brief  : Combinational one-step advance of the 8-bit Fibonacci LFSR:
//          shift left, feedback = XOR of the tapped bits into bit 0.
// Rev    : 1.0  initial release
// ============================================================================
module lfsr8_step
   import lfsr_keystream_arb_pkg::*;
(
   input  logic [c_lfsr_w-1:0] q,
   output logic [c_lfsr_w-1:0] q_next
);

   assign q_next = {q[c_lfsr_w-2:0], ^(q & c_lfsr_taps)};

endmodule
`default_nettype wire

// File: rtl/lfsr_keystream_arb.sv
`default_nettype none
// ============================================================================
// Module : lfsr_keystream_arb
// Brief  : Two-requester round-robin arbiter feeding an LFSR stream cipher.
//          Each accepted plaintext byte is XORed with the current keystream
//          byte and presented one cycle later on a single-entry output
//          register. A seed load starts a session of SESSION_LEN bytes.
// Rev    : 1.0  initial release
// ============================================================================
module lfsr_keystream_arb
   import lfsr_keystream_arb_pkg::*;
#(
   parameter int                    SESSION_LEN  = 16,
   parameter logic [c_lfsr_w-1:0]   DEFAULT_SEED = c_default_seed
)(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        ena,
   input  logic        seed_load,
   input  logic [7:0]  seed,
   input  logic [1:0]  req_valid,
   input  logic [15:0] req_data,
   output logic [1:0]  req_ready,
   output logic        out_valid,
   output logic [7:0]  out_data,
   output logic        out_id,
   input  logic        out_ready,
   output logic        busy,
   output logic [7:0]  byte_cnt
);

   // Count value at which the next accept closes the session.
   localparam logic [7:0] c_last_cnt = 8'(SESSION_LEN - 1);

   state_t              r_state;
   state_t              w_state_nxt;
   logic [c_lfsr_w-1:0] r_lfsr;
   logic [c_lfsr_w-1:0] w_lfsr_next;
   logic [7:0]          r_byte_cnt;
   logic                r_rr_ptr;      // requester holding priority on a tie
   logic                r_out_valid;
   logic [7:0]          r_out_data;
   logic                r_out_id;

   logic                w_load;
   logic                w_can_accept;
   logic                w_grant_id;
   logic                w_accept;
   logic [7:0]          w_sel_data;

   lfsr8_step u_step (
      .q      (r_lfsr),
      .q_next (w_lfsr_next)
   );

   // Arbitration: pick the winner and decide whether a byte can be taken now.
   always_comb begin
      w_load       = ena & seed_load;
      w_can_accept = (r_state == ST_RUN) & ena & ~seed_load
                     & (~r_out_valid | out_ready);
      if (req_valid == 2'b11) begin
         w_grant_id = r_rr_ptr;
      end else begin
         w_grant_id = req_valid[1];
      end
      w_accept   = w_can_accept & (|req_valid);
      w_sel_data = w_grant_id ? req_data[15:8] : req_data[7:0];
   end

   // Session state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else if (ena) begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic plus the state-derived outputs.
   always_comb begin
      w_state_nxt = r_state;
      req_ready   = 2'b00;
      busy        = (r_state == ST_RUN);
      if (w_accept) begin
         req_ready[w_grant_id] = 1'b1;
      end
      if (w_load) begin
         w_state_nxt = ST_RUN;
      end else if (w_accept && (r_byte_cnt == c_last_cnt)) begin
         w_state_nxt = ST_EXHAUSTED;
      end
   end

   // Keystream, byte counter and round-robin pointer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_lfsr     <= DEFAULT_SEED;
         r_byte_cnt <= 8'd0;
         r_rr_ptr   <= 1'b0;
      end else if (ena) begin
         if (w_load) begin
            r_lfsr     <= (seed == 8'd0) ? DEFAULT_SEED : seed;
            r_byte_cnt <= 8'd0;
         end else if (w_accept) begin
            r_lfsr     <= w_lfsr_next;
            r_byte_cnt <= r_byte_cnt + 8'd1;
            r_rr_ptr   <= ~w_grant_id;
         end
      end
   end

   // Single-entry output register; refill and drain may coincide.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out_valid <= 1'b0;
         r_out_data  <= 8'd0;
         r_out_id    <= 1'b0;
      end else if (ena) begin
         if (w_accept) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_sel_data ^ r_lfsr;
            r_out_id    <= w_grant_id;
         end else if (out_ready) begin
            r_out_valid <= 1'b0;
         end
      end
   end

   assign out_valid = r_out_valid;
   assign out_data  = r_out_data;
   assign out_id    = r_out_id;
   assign byte_cnt  = r_byte_cnt;

endmodule
`default_nettype wire

// File: tb/tb_lfsr_keystream_arb.sv
`default_nettype none
// ============================================================================
// Module : tb_lfsr_keystream_arb
// Brief  : Scoreboard bench for lfsr_keystream_arb: directed sessions plus a
//          randomized phase checked against a keystream/arbitration model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_lfsr_keystream_arb;

   localparam int c_len = 16;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        ena = 1'b0;
   logic        seed_load = 1'b0;
   logic [7:0]  seed = 8'd0;
   logic [1:0]  req_valid = 2'b00;
   logic [15:0] req_data = 16'd0;
   logic        out_ready = 1'b0;
   logic [1:0]  req_ready;
   logic        out_valid;
   logic [7:0]  out_data;
   logic        out_id;
   logic        busy;
   logic [7:0]  byte_cnt;

   int n_pass  = 0;
   int n_total = 0;

   // Model state, kept in specification terms.
   int         m_state = 0;       // 0 idle, 1 run, 2 exhausted
   int         m_cnt   = 0;       // bytes accepted this session
   logic       m_last  = 1'b1;    // most recently granted requester
   logic       m_pend  = 1'b0;    // output register occupied
   logic [7:0] m_ks [256];        // keystream of the current session
   logic [8:0] sb [$];            // expected {id, data}

   lfsr_keystream_arb #(.SESSION_LEN(c_len), .DEFAULT_SEED(8'h41)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .ena       (ena),
      .seed_load (seed_load),
      .seed      (seed),
      .req_valid (req_valid),
      .req_data  (req_data),
      .req_ready (req_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_id    (out_id),
      .out_ready (out_ready),
      .busy      (busy),
      .byte_cnt  (byte_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   function automatic logic [7:0] lstep(input logic [7:0] x);
      return {x[6:0], x[0] ^ x[5] ^ x[6] ^ x[7]};
   endfunction

   // One clock of stimulus; checks combinational outputs and advances the model.
   task automatic cycle(input logic e, input logic ld, input logic [7:0] sd,
                        input logic [1:0] v, input logic [15:0] d, input logic ordy);
      logic [1:0] exp_ready;
      logic       id;
      logic       acc;
      @(negedge clk);
      ena = e; seed_load = ld; seed = sd; req_valid = v; req_data = d; out_ready = ordy;
      #1;
      exp_ready = 2'b00;
      id = (v == 2'b11) ? ~m_last : v[1];
      acc = (m_state == 1) && e && !ld && (!m_pend || ordy) && (v != 2'b00);
      if (acc) exp_ready[id] = 1'b1;
      chk("req_ready", 32'(req_ready), 32'(exp_ready));
      chk("busy", 32'(busy), 32'(m_state == 1));
      chk("byte_cnt", 32'(byte_cnt), 32'(m_cnt));
      if (e) begin
         if (ld) begin
            m_state = 1;
            m_cnt   = 0;
            m_ks[0] = (sd == 8'd0) ? 8'h41 : sd;
            for (int k = 1; k < 256; k++) m_ks[k] = lstep(m_ks[k-1]);
         end else if (acc) begin
            sb.push_back({id, (id ? d[15:8] : d[7:0]) ^ m_ks[m_cnt]});
            m_cnt++;
            m_last = id;
            if (m_cnt == c_len) m_state = 2;
         end
         m_pend = acc ? 1'b1 : (ordy ? 1'b0 : m_pend);
      end
   endtask

   // Look at the output register right after the edge that loads it.
   task automatic peek(input logic [7:0] exp_d, input logic exp_id);
      @(posedge clk);
      #1;
      chk("peek_valid", 32'(out_valid), 32'd1);
      chk("peek_data", 32'(out_data), 32'(exp_d));
      chk("peek_id", 32'(out_id), 32'(exp_id));
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0; ena = 1'b0; seed_load = 1'b0; req_valid = 2'b00; out_ready = 1'b0;
      #1;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_data", 32'(out_data), 32'd0);
      chk("rst_out_id", 32'(out_id), 32'd0);
      chk("rst_byte_cnt", 32'(byte_cnt), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_req_ready", 32'(req_ready), 32'd0);
      m_state = 0; m_cnt = 0; m_last = 1'b1; m_pend = 1'b0;
      sb.delete();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Monitor: pops the scoreboard on every drain, checks stability while held.
   logic       held = 1'b0;
   logic [7:0] h_data;
   logic       h_id;
   logic [8:0] exp_item;
   always begin
      @(negedge clk);
      #2;
      if (!rst_n) begin
         held = 1'b0;
      end else begin
         if (held) chk("hold_stable", {22'd0, out_valid, out_id, out_data}, {22'd0, 1'b1, h_id, h_data});
         held = 1'b0;
         if (out_valid && ena && out_ready) begin
            if (sb.size() == 0) begin
               n_total++;
               $display("FAIL sb_pop: got %0h expected nothing pending", {out_id, out_data});
            end else begin
               exp_item = sb.pop_front();
               chk("sb_data", 32'({out_id, out_data}), 32'(exp_item));
            end
         end else if (out_valid) begin
            held = 1'b1; h_data = out_data; h_id = out_id;
         end
      end
   end

   initial begin
      do_reset();
      // Known-answer stream from requester 0 with seed 0x41.
      cycle(1, 1, 8'h41, 2'b00, 16'h0000, 1);
      cycle(1, 0, 8'h00, 2'b01, 16'h0000, 1); peek(8'h41, 0);
      cycle(1, 0, 8'h00, 2'b01, 16'h0000, 1); peek(8'h82, 0);
      cycle(1, 0, 8'h00, 2'b01, 16'h0000, 1); peek(8'h05, 0);
      cycle(1, 0, 8'h00, 2'b00, 16'h0000, 1);
      // Zero seed falls back to the default seed.
      cycle(1, 1, 8'h00, 2'b00, 16'h0000, 1);
      cycle(1, 0, 8'h00, 2'b01, 16'h00FF, 1); peek(8'hBE, 0);
      cycle(1, 0, 8'h00, 2'b00, 16'h0000, 1);
      // Both requesters valid: alternating grants.
      do_reset();
      cycle(1, 1, 8'h41, 2'b00, 16'h0000, 1);
      cycle(1, 0, 8'h00, 2'b11, 16'h0000, 1); peek(8'h41, 0);
      cycle(1, 0, 8'h00, 2'b11, 16'h0000, 1); peek(8'h82, 1);
      cycle(1, 0, 8'h00, 2'b11, 16'h0000, 1); peek(8'h05, 0);
      cycle(1, 0, 8'h00, 2'b11, 16'h0000, 1); peek(8'h0B, 1);
      cycle(1, 0, 8'h00, 2'b00, 16'h0000, 1);
      // Exhaust a full session, then restart it.
      cycle(1, 1, 8'h5A, 2'b00, 16'h0000, 1);
      for (int i = 0; i < c_len; i++) cycle(1, 0, 8'h00, 2'b01, 16'($urandom), 1);
      cycle(1, 0, 8'h00, 2'b11, 16'h1234, 1);
      cycle(1, 0, 8'h00, 2'b11, 16'h1234, 1);
      cycle(1, 1, 8'h77, 2'b00, 16'h0000, 1);
      cycle(1, 0, 8'h00, 2'b10, 16'hA500, 1);
      // Downstream stall for five cycles, then release.
      for (int i = 0; i < 5; i++) cycle(1, 0, 8'h00, 2'b11, 16'($urandom), 0);
      for (int i = 0; i < 3; i++) cycle(1, 0, 8'h00, 2'b11, 16'($urandom), 1);
      // Reset with an output pending.
      cycle(1, 0, 8'h00, 2'b01, 16'h00C3, 0);
      do_reset();
      cycle(1, 0, 8'h00, 2'b11, 16'h0000, 1);
      // Enable low freezes everything and ignores seed loads.
      cycle(1, 1, 8'h3C, 2'b00, 16'h0000, 1);
      cycle(1, 0, 8'h00, 2'b01, 16'h0011, 1);
      cycle(1, 0, 8'h00, 2'b01, 16'h0022, 0);
      for (int i = 0; i < 4; i++) cycle(0, 1, 8'h99, 2'b11, 16'($urandom), 1);
      for (int i = 0; i < 3; i++) cycle(1, 0, 8'h00, 2'b01, 16'($urandom), 1);
      // Randomized traffic.
      for (int i = 0; i < 800; i++) begin
         if ($urandom_range(0, 199) == 0) begin
            do_reset();
         end else begin
            cycle($urandom_range(0, 9) != 0,
                  $urandom_range(0, 29) == 0,
                  ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom),
                  2'($urandom), 16'($urandom),
                  $urandom_range(0, 9) < 7);
         end
      end
      for (int i = 0; i < 4; i++) cycle(1, 0, 8'h00, 2'b00, 16'h0000, 1);
      chk("sb_drained", 32'(sb.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/lfsr_keystream_arb.md
LFSR_KEYSTREAM_ARB -- requirements
Module: lfsr_keystream_arb

Interface
REQ-001 Parameter SESSION_LEN, default 16, sets the number of bytes encrypted per seed load (range 1..255).
REQ-002 Parameter DEFAULT_SEED, default 8'h41, is the substitute seed used whenever a zero seed is loaded.
REQ-003 clk  in  1  clock; all state changes on the rising edge.
REQ-004 rst_n  in  1  reset: asynchronous, active-low.
REQ-005 ena  in  1  global enable; low freezes all state.
REQ-006 seed_load  in  1  single-cycle pulse that loads seed and starts a session.
REQ-007 seed  in  8  seed value, sampled when seed_load=1.
REQ-008 req_valid  in  2  per-requester data valid (bit 0 = requester 0).
REQ-009 req_data  in  16  plaintext bytes; [7:0] belongs to requester 0, [15:8] to requester 1.
REQ-010 req_ready  out  2  per-requester grant; at most one bit high per cycle.
REQ-011 out_valid  out  1  ciphertext valid.
REQ-012 out_data  out  8  ciphertext byte.
REQ-013 out_id  out  1  index of the requester that owns out_data.
REQ-014 out_ready  in  1  downstream accept.
REQ-015 busy  out  1  high in RUN state.
REQ-016 byte_cnt  out  8  bytes accepted in the current session.

Function
REQ-017 The FSM SHALL have three states: IDLE (no seed loaded), RUN, and EXHAUSTED.
REQ-018 IDLE SHALL move to RUN on seed_load; EXHAUSTED SHALL move to RUN on seed_load; RUN SHALL re-enter RUN on seed_load.
REQ-019 On seed_load the LFSR SHALL load seed (or DEFAULT_SEED if seed==0), byte_cnt SHALL clear to 0, and no request SHALL be accepted in that cycle.
REQ-020 LFSR step SHALL be next = {q[6:0], q[0]^q[5]^q[6]^q[7]}.
REQ-021 The LFSR SHALL advance exactly once per accepted byte and SHALL otherwise hold.
REQ-022 A byte SHALL be accepted when req_valid[i] & req_ready[i]; req_ready SHALL be asserted only in RUN, with ena=1, seed_load=0, and the output register either empty or draining this cycle (out_ready=1).
REQ-023 Arbitration SHALL be round-robin: when both requesters are valid, grant the one not granted most recently; a lone valid requester SHALL be granted immediately. The priority pointer SHALL reset to requester 0.
REQ-024 The accepted byte SHALL appear on the next cycle as out_data = req_data_i ^ lfsr_q (the pre-step value), with out_id = i and out_valid = 1 (latency 1).
REQ-025 out_valid/out_data/out_id SHALL hold stable until out_ready=1; a simultaneous drain and accept SHALL replace the entry with no bubble.
REQ-026 byte_cnt SHALL increment per accepted byte; an accept at byte_cnt == SESSION_LEN-1 SHALL set byte_cnt = SESSION_LEN and move the FSM to EXHAUSTED.
REQ-027 In EXHAUSTED, req_ready SHALL be 0 and a pending output SHALL still drain.
REQ-028 seed_load with a pending output SHALL leave that output intact.
REQ-029 With ena=0, the FSM, LFSR, counter, pointer, and output register SHALL hold; req_ready SHALL be 0; a seed_load during ena=0 SHALL be ignored.

Reset
REQ-030 Asserting rst_n SHALL immediately force IDLE, lfsr_q=DEFAULT_SEED, byte_cnt=0, out_valid=0, out_data=0, out_id=0, req_ready=0, busy=0, and the pointer to requester 0.
REQ-031 Reset mid-session SHALL discard any pending output; after reset, a seed_load is required before any accept.

Structure
REQ-032 A shared package SHALL hold the state enum, the LFSR tap positions, the DEFAULT_SEED value, and the LFSR width (8).
REQ-033 One sub-module, lfsr8_step, SHALL compute the combinational next-state function.
REQ-034 Arbiter and FSM logic SHALL be inline; no other sub-modules.

Verification
REQ-035 Reset, then seed_load seed=0x41, then requester 0 sends 0x00 three times with out_ready=1 -> out_data 0x41, 0x82, 0x05, out_id=0, each one cycle after accept.
REQ-036 seed=0x00 load, then send 0xFF -> out_data 0xBE (the DEFAULT_SEED 0x41 is used).
REQ-037 Both requesters continuously valid -> grants alternate 0,1,0,1; out_id follows; ciphertext uses the consecutive LFSR values 0x41, 0x82, 0x05, ...
REQ-038 SESSION_LEN=16, stream 16 bytes -> byte_cnt=16, FSM in EXHAUSTED, busy=0, req_ready=0; a new seed_load restarts with byte_cnt=0.
REQ-039 Hold out_ready=0 for 5 cycles with a pending output -> out_data is stable, req_ready=0, and the LFSR does not step; release -> no byte is lost or duplicated.
REQ-040 Assert rst_n low mid-stream, and separately toggle ena=0 mid-stream -> reset gives the REQ-030 values immediately; ena=0 freezes byte_cnt, the LFSR, and the output.
